// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   fwd_sel_t    : E-stage operand forwarding select (register file, W result, M alu_result)
//   miss_state_t : data-cache miss FSM states (RUN, MISS, REFILL)
//   RESULT_SRC_LOAD : result_src encoding that marks a load instruction
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        MISS   = 2'b01,
        REFILL = 2'b10
    } miss_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// forward_unit: combinational forwarding select for one E-stage source operand.
//   src_i                    : source register of the E-stage operand
//   rdM_i, reg_writeM_i      : M-stage destination and write enable
//   rdW_i, reg_writeW_i      : W-stage destination and write enable
//   sel_o                    : fwd_sel_t encoding (00 reg, 01 W result, 10 M alu_result)
// M has priority over W because it holds the younger value of the register.
module forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
    input  logic                      reg_writeM_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
    input  logic                      reg_writeW_i,
    output logic [1:0]                sel_o
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_REG;
        if (reg_writeM_i && (rdM_i != '0) && (src_i == rdM_i)) begin
            sel = FWD_M;
        end else if (reg_writeW_i && (rdW_i != '0) && (src_i == rdW_i)) begin
            sel = FWD_W;
        end
    end

    assign sel_o = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central pipeline controller of the 5-stage core.
//   Drives stall/flush enables of the F/D, D/E, E/M, M/W pipe registers, the E-stage
//   forwarding selects, and the data-cache miss FSM (RUN -> MISS -> REFILL -> RUN).
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   rs1D_i, rs2D_i                decode source registers (load-use check)
//   rs1E_i, rs2E_i                execute source registers (forwarding)
//   rdE_i, rdM_i, rdW_i           destination registers in E/M/W
//   reg_writeM_i, reg_writeW_i    M/W stage write enables
//   result_srcE_i                 E-stage result select (01 = load)
//   pc_srcE_i                     taken branch/jump resolved in E
//   mem_accessM_i, cache_hitM_i   M-stage memory access and its cache hit
//   fill_ready_i                  backend refill data valid (1-cycle pulse)
//   forward_aE_o, forward_bE_o    ALU operand forwarding selects
//   stallF_o..stallM_o            hold pipe registers
//   flushD_o, flushE_o, flushW_o  clear pipe registers to a bubble
//   fill_req_o, fill_we_o         refill request / cache line write enable
//   miss_timeout_o                sticky: a miss exceeded MISS_TIMEOUT cycles
//   state_o                       current miss FSM state (debug)
//   stall_cycles_o, miss_count_o  performance counters (HAZARD_PERF_CNT_EN only)
// Configuration: define HAZARD_PERF_CNT_EN to add the performance counters.
//
// Refill handshake: fill_req_o is a level request raised in MISS and held until the
// cycle in which the backend pulses fill_ready_i; that cycle completes the transfer
// and the FSM moves to REFILL on the next edge.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MISS_TIMEOUT   = 255
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH      = 32
`endif
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
    input  logic                      reg_writeM_i,
    input  logic                      reg_writeW_i,
    input  logic [1:0]                result_srcE_i,
    input  logic                      pc_srcE_i,
    input  logic                      mem_accessM_i,
    input  logic                      cache_hitM_i,
    input  logic                      fill_ready_i,
    output logic [1:0]                forward_aE_o,
    output logic [1:0]                forward_bE_o,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      stallE_o,
    output logic                      stallM_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic                      flushW_o,
    output logic                      fill_req_o,
    output logic                      fill_we_o,
    output logic                      miss_timeout_o,
    output logic [1:0]                state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      stall_cycles_o,
    output logic [CNT_WIDTH-1:0]      miss_count_o
`endif
);

    localparam int CW = $clog2(MISS_TIMEOUT + 1);
    // Counter value during the last allowed MISS cycle; the edge ending it times out.
    localparam logic [CW-1:0] CNT_LAST = CW'(MISS_TIMEOUT - 1);

    // ---------------- forwarding ----------------
    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .src_i        (rs1E_i),
        .rdM_i        (rdM_i),
        .reg_writeM_i (reg_writeM_i),
        .rdW_i        (rdW_i),
        .reg_writeW_i (reg_writeW_i),
        .sel_o        (forward_aE_o)
    );

    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .src_i        (rs2E_i),
        .rdM_i        (rdM_i),
        .reg_writeM_i (reg_writeM_i),
        .rdW_i        (rdW_i),
        .reg_writeW_i (reg_writeW_i),
        .sel_o        (forward_bE_o)
    );

    // ---------------- miss FSM ----------------
    miss_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
    logic          fill_req_q;
    logic          fill_we_q;
    logic          freeze_q;   // high in MISS and REFILL
    logic          miss_start;

    assign miss_start = mem_accessM_i && !cache_hitM_i;

    // Moore outputs are registered alongside the state, so they always match state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            fill_req_q <= 1'b0;
            fill_we_q  <= 1'b0;
            freeze_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (miss_start) begin
                        state_q    <= MISS;
                        cnt_q      <= '0;
                        fill_req_q <= 1'b1;
                        freeze_q   <= 1'b1;
                    end
                end
                MISS: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A refill arriving in the last allowed cycle still completes the miss.
                    if (fill_ready_i) begin
                        state_q    <= REFILL;
                        fill_req_q <= 1'b0;
                        fill_we_q  <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= RUN;
                        timeout_q  <= 1'b1;
                        fill_req_q <= 1'b0;
                        freeze_q   <= 1'b0;
                    end
                end
                REFILL: begin
                    state_q   <= RUN;
                    fill_we_q <= 1'b0;
                    freeze_q  <= 1'b0;
                end
                default: begin
                    state_q    <= RUN;
                    fill_req_q <= 1'b0;
                    fill_we_q  <= 1'b0;
                    freeze_q   <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- stall / flush ----------------
    logic lw;
    assign lw = (result_srcE_i == RESULT_SRC_LOAD) && (rdE_i != '0) &&
                ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

    // While frozen the E stage is held, so load-use and branch flushes are dropped
    // here and naturally reappear once the pipe runs again.
    assign stallF_o       = freeze_q | lw;
    assign stallD_o       = freeze_q | lw;
    assign stallE_o       = freeze_q;
    assign stallM_o       = freeze_q;
    assign flushD_o       = !freeze_q && pc_srcE_i;
    assign flushE_o       = !freeze_q && (lw || pc_srcE_i);
    assign flushW_o       = freeze_q;
    assign fill_req_o     = fill_req_q;
    assign fill_we_o      = fill_we_q;
    assign miss_timeout_o = timeout_q;
    assign state_o        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    // ---------------- performance counters ----------------
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        miss_count_d   = miss_count_q;
        if (stallF_o) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
        if ((state_q == RUN) && miss_start) begin
            miss_count_d = miss_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            miss_count_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign miss_count_o   = miss_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int RW = 5;
  localparam int TO = 12;
  localparam int W  = 16;
  localparam int S_RUN = 0;
  localparam int S_MISS = 1;
  localparam int S_REFILL = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_i;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic [RW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic reg_writeM, reg_writeW, pc_srcE, mem_accessM, cache_hitM, fill_ready;
  logic [1:0] result_srcE;
  logic [1:0] fwd_a, fwd_b, state;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic fill_req, fill_we, miss_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, miss_count;
`endif

  hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MISS_TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .rs1D_i         (rs1D),
    .rs2D_i         (rs2D),
    .rs1E_i         (rs1E),
    .rs2E_i         (rs2E),
    .rdE_i          (rdE),
    .rdM_i          (rdM),
    .rdW_i          (rdW),
    .reg_writeM_i   (reg_writeM),
    .reg_writeW_i   (reg_writeW),
    .result_srcE_i  (result_srcE),
    .pc_srcE_i      (pc_srcE),
    .mem_accessM_i  (mem_accessM),
    .cache_hitM_i   (cache_hitM),
    .fill_ready_i   (fill_ready),
    .forward_aE_o   (fwd_a),
    .forward_bE_o   (fwd_b),
    .stallF_o       (stallF),
    .stallD_o       (stallD),
    .stallE_o       (stallE),
    .stallM_o       (stallM),
    .flushD_o       (flushD),
    .flushE_o       (flushE),
    .flushW_o       (flushW),
    .fill_req_o     (fill_req),
    .fill_we_o      (fill_we),
    .miss_timeout_o (miss_timeout),
    .state_o        (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cycles),
    .miss_count_o   (miss_count)
`endif
  );

  // ---------------- reference model ----------------
  // The model tracks the controller as the pipeline sees it: which phase of a miss
  // it is in, how many miss cycles have elapsed, the sticky error and the counts.
  int          m_mode;
  int          m_miss_cycles;
  bit          m_timeout;
  int unsigned m_stalls;
  int unsigned m_misses;

  logic [W-1:0] exp_q[$];
  logic [63:0]  cnt_exp_q[$];
  int n_checks;
  int n_pass;
  int cyc;

  function automatic logic [1:0] fwd_model(input logic [RW-1:0] src);
    if (reg_writeM && rdM != 0 && src == rdM) return 2'b10;
    if (reg_writeW && rdW != 0 && src == rdW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_mode = S_RUN;
    m_miss_cycles = 0;
    m_timeout = 1'b0;
    m_stalls = 0;
    m_misses = 0;
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
    rdE = '0; rdM = '0; rdW = '0;
    reg_writeM = 1'b0; reg_writeW = 1'b0;
    result_srcE = 2'b00; pc_srcE = 1'b0;
    mem_accessM = 1'b0; cache_hitM = 1'b0; fill_ready = 1'b0;
    rst_i = 1'b0;
  endtask

  // Predicts this cycle's outputs from the current inputs, queues them for the
  // monitor, advances the model across the coming edge, then waits for that edge.
  task automatic step();
    logic [1:0] fa, fb, st;
    logic sF, sD, sE, sM, fD, fE, fW, req, we;
    logic [W-1:0] e;
    bit load_use;
    fa = fwd_model(rs1E);
    fb = fwd_model(rs2E);
    load_use = (result_srcE == 2'b01) && (rdE != 0) && (rdE == rs1D || rdE == rs2D);
    {sF, sD, sE, sM, fD, fE, fW, req, we} = '0;
    if (m_mode == S_RUN) begin
      sF = load_use;
      sD = load_use;
      fE = load_use || pc_srcE;
      fD = pc_srcE;
      st = 2'd0;
    end else begin
      {sF, sD, sE, sM, fW} = 5'b11111;
      req = (m_mode == S_MISS);
      we  = (m_mode == S_REFILL);
      st  = (m_mode == S_MISS) ? 2'd1 : 2'd2;
    end
    e = {fa, fb, sF, sD, sE, sM, fD, fE, fW, req, we, m_timeout, st};
    exp_q.push_back(e);
    cnt_exp_q.push_back({m_stalls, m_misses});

    if (rst_i) begin
      model_reset();
    end else begin
      if (sF) m_stalls++;
      if (m_mode == S_RUN) begin
        if (mem_accessM && !cache_hitM) begin
          m_mode = S_MISS;
          m_miss_cycles = 0;
          m_misses++;
        end
      end else if (m_mode == S_MISS) begin
        m_miss_cycles++;
        if (fill_ready) begin
          m_mode = S_REFILL;
        end else if (m_miss_cycles == TO) begin
          m_timeout = 1'b1;
          m_mode = S_RUN;
        end
      end else begin
        m_mode = S_RUN;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] act;
  assign act = {fwd_a, fwd_b, stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                fill_req, fill_we, miss_timeout, state};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [63:0] ce;
      e = exp_q.pop_front();
      ce = cnt_exp_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL outputs cycle %0d: got %h required %h (fa fb sF sD sE sM fD fE fW req we to st)",
                    cyc, act, e);
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if ({stall_cycles, miss_count} === ce) n_pass++;
      else $display("FAIL perf_counters cycle %0d: got %h required %h", cyc, {stall_cycles, miss_count}, ce);
`endif
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    idle();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // reset state
    step();
    step();

    // forwarding: M beats W, then W when rdM is x0
    rdM = 5; reg_writeM = 1; rdW = 5; reg_writeW = 1; rs1E = 5; rs2E = 5;
    step();
    rdM = 0;
    step();
    rdM = 3; rs2E = 3; reg_writeM = 0;
    step();
    idle();

    // load-use: one bubble, then the load has moved on
    result_srcE = 2'b01; rdE = 7; rs2D = 7;
    step();
    idle();
    step();
    // load to x0 never stalls
    result_srcE = 2'b01; rdE = 0; rs1D = 0;
    step();
    idle();

    // taken branch
    pc_srcE = 1;
    step();
    idle();
    step();

    // miss, refill after 10 MISS cycles, branch/load-use suppressed while frozen
    mem_accessM = 1; cache_hitM = 0;
    step();
    idle();
    for (int i = 0; i < 9; i++) begin
      pc_srcE = (i == 3);
      result_srcE = (i == 5) ? 2'b01 : 2'b00; rdE = 4; rs1D = 4;
      step();
    end
    idle();
    fill_ready = 1;
    step();
    idle();
    step();
    mem_accessM = 1; cache_hitM = 1;
    step();
    idle();
    step();

    // timeout: no refill ever, error stays set afterwards
    mem_accessM = 1; cache_hitM = 0;
    step();
    idle();
    for (int i = 0; i < TO + 3; i++) step();
    // a new miss with the error already set
    mem_accessM = 1; cache_hitM = 0;
    step();
    idle();
    repeat (3) step();

    // reset in MISS
    rst_i = 1;
    step();
    idle();
    step();
    step();

    // reset in REFILL
    mem_accessM = 1; cache_hitM = 0;
    step();
    idle();
    fill_ready = 1;
    step();
    idle();
    rst_i = 1;
    step();
    idle();
    step();

    // miss and branch in the same RUN cycle
    mem_accessM = 1; cache_hitM = 0; pc_srcE = 1;
    step();
    idle();
    step();
    fill_ready = 1;
    step();
    idle();
    step();
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs1D = RW'($urandom_range(0, 7));
      rs2D = RW'($urandom_range(0, 7));
      rs1E = RW'($urandom_range(0, 7));
      rs2E = RW'($urandom_range(0, 7));
      rdE  = RW'($urandom_range(0, 7));
      rdM  = RW'($urandom_range(0, 7));
      rdW  = RW'($urandom_range(0, 7));
      reg_writeM  = 1'($urandom_range(0, 1));
      reg_writeW  = 1'($urandom_range(0, 1));
      result_srcE = 2'($urandom_range(0, 3));
      pc_srcE     = ($urandom_range(0, 5) == 0);
      mem_accessM = ($urandom_range(0, 3) == 0);
      cache_hitM  = 1'($urandom_range(0, 1));
      fill_ready  = ($urandom_range(0, 6) == 0);
      rst_i       = ($urandom_range(0, 99) == 0);
      step();
    end
    idle();
    step();

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
